// File: rtl/sdram_aref.sv
// SDRAM auto-refresh scheduler: interval timer, pending-refresh backlog, PRE/AREF sequencer.
// Define SDRAM_AREF_PRE_EN to precede each AUTO REFRESH with a PRECHARGE ALL.
module sdram_aref #(
  parameter int REF_PERIOD = 390,
  parameter int TRP_CYC    = 2,
  parameter int TRFC_CYC   = 7,
  parameter int MAX_PEND   = 8
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        flag_init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic        flag_aref_end,
  output logic [3:0]  aref_cmd,
  output logic [12:0] aref_addr,
  output logic        aref_pend_ovf
);

  localparam int CNT_W    = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int PEND_W   = $clog2(MAX_PEND + 1);
  localparam int WAIT_MAX = (TRFC_CYC > TRP_CYC) ? TRFC_CYC : TRP_CYC;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REF_PERIOD - 1);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_PEND);
  localparam logic [WAIT_W-1:0] TRFC_LAST = WAIT_W'(TRFC_CYC - 2);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

`ifdef SDRAM_AREF_PRE_EN
  localparam logic [WAIT_W-1:0] TRP_LAST = WAIT_W'(TRP_CYC - 2);
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRP, AREF, WAIT_TRFC, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, AREF, WAIT_TRFC, DONE} state_t;
`endif

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [PEND_W-1:0]   pend;
  logic [WAIT_W-1:0]   wcnt;
  logic                tick;
  logic                done;

  assign tick          = flag_init_end && (cnt == CNT_LAST);
  assign done          = (state == DONE);
  assign flag_aref_end = done;
  assign aref_req      = (state == IDLE) && (pend != '0);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)           cnt <= '0;
    else if (!flag_init_end) cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                    cnt <= cnt + CNT_W'(1);
  end

  // A tick coinciding with a completion cancels out, even when saturated.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      pend          <= '0;
      aref_pend_ovf <= 1'b0;
    end else if (tick && !done) begin
      if (pend == PEND_FULL) aref_pend_ovf <= 1'b1;
      else                   pend <= pend + PEND_W'(1);
    end else if (done && !tick) begin
      pend <= pend - PEND_W'(1);
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= next_state;
      wcnt  <= (next_state != state) ? '0 : wcnt + WAIT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (aref_req && aref_en) begin
`ifdef SDRAM_AREF_PRE_EN
          next_state = PRE;
`else
          next_state = AREF;
`endif
        end
      end
`ifdef SDRAM_AREF_PRE_EN
      PRE:       next_state = (TRP_CYC > 1) ? WAIT_TRP : AREF;
      WAIT_TRP:  if (wcnt == TRP_LAST) next_state = AREF;
`endif
      AREF:      next_state = (TRFC_CYC > 1) ? WAIT_TRFC : DONE;
      WAIT_TRFC: if (wcnt == TRFC_LAST) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Decoded from next_state so the command appears in the cycle its state is occupied.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      aref_cmd  <= CMD_NOP;
      aref_addr <= '0;
    end else begin
      aref_cmd  <= CMD_NOP;
      aref_addr <= '0;
`ifdef SDRAM_AREF_PRE_EN
      if (next_state == PRE) begin
        aref_cmd  <= CMD_PRE;
        aref_addr <= 13'h0400;
      end
`endif
      if (next_state == AREF) aref_cmd <= CMD_AREF;
    end
  end

endmodule

// File: doc/sdram_aref.md
SDRAM_AREF -- requirements
Module: sdram_aref

Interface
REQ-001 SHALL have parameters: REF_PERIOD, default 390, refresh interval in sclk cycles (7.8 us at 50 MHz); TRP_CYC, default 2, precharge-to-refresh spacing; TRFC_CYC, default 7, refresh-to-done spacing; MAX_PEND, default 8, pending-refresh saturation limit.
REQ-002 SHALL have ports:
- sclk  in  1  sole clock, rising edge.
- s_rst_n  in  1  asynchronous active-low reset.
- flag_init_end  in  1  SDRAM power-up init complete; level, monotonic after reset.
- aref_en  in  1  grant from command arbiter.
- aref_req  out  1  refresh request to arbiter.
- flag_aref_end  out  1  one-cycle pulse, refresh sequence finished.
- aref_cmd  out  4  {cs,ras,cas,we}; NOP 4'b0111, PRE 4'b0010, AREF 4'b0001.
- aref_addr  out  13  SDRAM address bus during this block's commands.
- aref_pend_ovf  out  1  sticky: refresh tick lost at saturation.

Function
REQ-003 SHALL hold interval counter at 0 while flag_init_end=0; once 1, count 0..REF_PERIOD-1 and wrap, asserting an internal tick on the REF_PERIOD-1 cycle.
REQ-004 SHALL keep pending count pend (0..MAX_PEND): tick alone -> +1; sequence completion alone -> -1; both in same cycle -> unchanged.
REQ-005 SHALL saturate pend at MAX_PEND; a tick arriving at MAX_PEND without simultaneous completion SHALL set aref_pend_ovf, cleared only by reset.
REQ-006 SHALL drive aref_req = (state==IDLE) && (pend!=0), combinationally; request stays high until granted.
REQ-007 SHALL use FSM states IDLE, PRE, WAIT_TRP, AREF, WAIT_TRFC, DONE.
REQ-008 IDLE -> PRE (or AREF when precharge disabled, REQ-016) on a cycle where aref_req=1 and aref_en=1; aref_en while aref_req=0 SHALL be ignored.
REQ-009 PRE lasts 1 cycle, then WAIT_TRP for TRP_CYC-1 cycles, then AREF for 1 cycle, then WAIT_TRFC for TRFC_CYC-1 cycles, then DONE for 1 cycle, then IDLE.
REQ-010 aref_cmd and aref_addr SHALL be registered: valid in the cycle the FSM occupies the corresponding state; PRE state -> cmd PRE, addr 13'h0400 (A10=1, all banks); AREF state -> cmd AREF, addr 13'h0000; all other states -> NOP, 13'h0000.
REQ-011 flag_aref_end SHALL be 1 exactly in the DONE cycle; pend decrement occurs on the same edge.
REQ-012 With grant sampled in cycle N (defaults, precharge enabled): PRE in N+1, AREF in N+3, flag_aref_end in N+10, aref_req may reassert in N+11.
REQ-013 Ticks during an active sequence SHALL only increment pend; no sequence is aborted or restarted.

Reset
REQ-014 s_rst_n=0 SHALL immediately force: state IDLE, interval counter 0, pend 0, aref_cmd NOP, aref_addr 0, aref_req 0, flag_aref_end 0, aref_pend_ovf 0, including mid-sequence.
REQ-015 After reset release no request SHALL occur before flag_init_end=1 plus REF_PERIOD cycles.

Configuration
REQ-016 Macro SDRAM_AREF_PRE_EN: defined -> PRE and WAIT_TRP states present as REQ-009; undefined -> those states SHALL not exist, grant goes IDLE -> AREF, AREF in N+1, flag_aref_end in N+1+TRFC_CYC (N+8 at defaults); TRP_CYC unused.

Verification
REQ-017 Reset, flag_init_end=1 at cycle 0, aref_en tied 1 -> aref_req first high at cycle 390; PRE at 391, AREF at 393, flag_aref_end at 400, pend back to 0.
REQ-018 aref_en held 0 for 3*390 cycles -> pend=3, aref_req steady 1; then aref_en=1 -> three back-to-back sequences, three flag_aref_end pulses 10 cycles apart (plus 1 idle cycle each).
REQ-019 aref_en held 0 for 9*390 cycles -> pend saturates at 8, aref_pend_ovf=1 at the 9th tick and stays 1 after grants drain pend.
REQ-020 Drive a tick exactly in a DONE cycle -> pend unchanged, no ovf, aref_req 1 in following cycle.
REQ-021 Assert s_rst_n=0 during WAIT_TRFC -> aref_cmd NOP and all outputs reset values same cycle; no flag_aref_end emitted.
REQ-022 Build without SDRAM_AREF_PRE_EN, grant at cycle N -> AREF at N+1, no PRE command ever, flag_aref_end at N+8.
